// File: rtl/shift_rotate_unit_pkg.sv
// Shared ALU definitions for the shift/rotate unit: op codes, FSM state
// encoding and the ceil(log2) helper used to size counters.
package shift_rotate_unit_pkg;

    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic int sru_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic is_shift_op(input logic [4:0] op);
        case (op)
            OP_SHR, OP_SHRA, OP_SHL, OP_ROL, OP_ROR: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shift_rotate_unit_if.sv
// Request/response bundle between the control sequencer and the shift unit.
// With SHIFT_FLAGS_EN defined the bundle also carries flag_z/flag_n/flag_c.
interface shift_rotate_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       op_code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] amt;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             illegal;
`ifdef SHIFT_FLAGS_EN
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;

    modport master (output start, op_code, a, amt,
                    input  result, busy, done, illegal, flag_z, flag_n, flag_c);
    modport slave  (input  start, op_code, a, amt,
                    output result, busy, done, illegal, flag_z, flag_n, flag_c);
`else
    modport master (output start, op_code, a, amt,
                    input  result, busy, done, illegal);
    modport slave  (input  start, op_code, a, amt,
                    output result, busy, done, illegal);
`endif
endinterface

// File: rtl/shift_rotate_unit_shift_step_mux.sv
// Combinational single-step shifter: moves din by k positions for the given op.
// The carry output exists only when SHIFT_FLAGS_EN is defined.
module shift_step_mux
    import shift_rotate_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 6
) (
    input  logic [4:0]       op,
    input  logic [KW-1:0]    k,
    input  logic [WIDTH-1:0] din,
`ifdef SHIFT_FLAGS_EN
    output logic             cout,
`endif
    output logic [WIDTH-1:0] dout
);
    // kc_s is the complementary distance; k=0 pushes both helper shifts off the end
    logic [KW-1:0] kc_s;
    assign kc_s = KW'(WIDTH) - k;

    // Shift or rotate din by k for the selected op
    always_comb begin
        dout = din;
        case (op)
            OP_SHL:  dout = din << k;
            OP_SHR:  dout = din >> k;
            OP_SHRA: dout = $signed(din) >>> k;
            OP_ROL:  dout = (din << k) | (din >> kc_s);
            OP_ROR:  dout = (din >> k) | (din << kc_s);
            default: dout = din;
        endcase
    end

`ifdef SHIFT_FLAGS_EN
    logic [WIDTH-1:0] up_s;
    logic [WIDTH-1:0] dn_s;
    assign up_s = din >> kc_s;
    assign dn_s = din >> (k - KW'(1));

    // Last bit leaving the word (or crossing the wrap) in this step
    always_comb begin
        cout = 1'b0;
        case (op)
            OP_SHL, OP_ROL:          cout = up_s[0];
            OP_SHR, OP_SHRA, OP_ROR: cout = dn_s[0];
            default:                 cout = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit moving up to STEP bits per clock.
// Optional flag outputs are enabled by defining SHIFT_FLAGS_EN.
module shift_rotate_unit
    import shift_rotate_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input logic                clk,
    input logic                clr,
    shift_rotate_unit_if.slave bus
);
    localparam int LW = sru_clog2(WIDTH);
    localparam int KW = LW + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [KW-1:0]    rem_q, rem_d;
    logic [4:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic             accept_s;
    logic [KW-1:0]    eff_s;
    logic [KW-1:0]    k_s;
    logic [WIDTH-1:0] step_out_s;

    assign accept_s = bus.start & ~busy_q & (state_q != ST_RUN);
    assign k_s      = (rem_q > KW'(STEP)) ? KW'(STEP) : rem_q;

    // Effective amount: rotates wrap, shifts saturate at WIDTH, illegal ops do nothing
    always_comb begin
        eff_s = '0;
        case (bus.op_code)
            OP_ROL, OP_ROR:          eff_s = {1'b0, bus.amt[LW-1:0]};
            OP_SHL, OP_SHR, OP_SHRA: eff_s = (bus.amt >= WIDTH'(WIDTH)) ? KW'(WIDTH)
                                                                       : bus.amt[KW-1:0];
            default:                 eff_s = '0;
        endcase
    end

`ifdef SHIFT_FLAGS_EN
    logic step_cout_s;
`endif

    shift_step_mux #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .op   (op_q),
        .k    (k_s),
        .din  (sr_q),
`ifdef SHIFT_FLAGS_EN
        .cout (step_cout_s),
`endif
        .dout (step_out_s)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d = (eff_s == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN:  state_d = (rem_q <= KW'(STEP)) ? ST_DONE : ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, step while running
    always_comb begin
        sr_d  = sr_q;
        rem_d = rem_q;
        op_d  = op_q;
        if (accept_s) begin
            sr_d  = bus.a;
            rem_d = eff_s;
            op_d  = bus.op_code;
        end else if (state_q == ST_RUN) begin
            sr_d  = step_out_s;
            rem_d = rem_q - k_s;
        end else begin
            sr_d  = sr_q;
        end
    end

    // Output decode from the upcoming state so the outputs come straight off flops
    always_comb begin
        busy_d    = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
        illegal_d = (state_d == ST_DONE) & ~is_shift_op(op_d);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            rem_q     <= '0;
            op_q      <= 5'b00000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            rem_q     <= rem_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.result  = sr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;

`ifdef SHIFT_FLAGS_EN
    logic carry_q, carry_d;
    logic flag_z_q, flag_z_d;
    logic flag_n_q, flag_n_d;
    logic flag_c_q, flag_c_d;

    // Track the last carry of the running op; a fresh accept clears it
    always_comb begin
        carry_d = carry_q;
        if (accept_s) begin
            carry_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            carry_d = step_cout_s;
        end else begin
            carry_d = carry_q;
        end
        flag_z_d = (state_d == ST_DONE) & (sr_d == '0);
        flag_n_d = (state_d == ST_DONE) & sr_d[WIDTH-1];
        flag_c_d = (state_d == ST_DONE) & carry_d;
    end

    // Flag registers
    always_ff @(posedge clk) begin
        if (!clr) begin
            carry_q  <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            carry_q  <= carry_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign bus.flag_z = flag_z_q;
    assign bus.flag_n = flag_n_q;
    assign bus.flag_c = flag_c_q;
`endif

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Scoreboard bench for shift_rotate_unit (WIDTH=32, STEP=4); flag checks are
// compiled in when SHIFT_FLAGS_EN is defined.
module tb_shift_rotate_unit;
    import shift_rotate_unit_pkg::*;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    shift_rotate_unit_if #(.WIDTH(WIDTH)) bus ();
    shift_rotate_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (.clk(clk), .clr(clr), .bus(bus));

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             ill;
        int               lat;
        logic             fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Bit-level reference model of one whole operation
    function automatic exp_t model(input logic [4:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] amt);
        exp_t e;
        int   eff;
        e.ill = 1'b0;
        e.fc  = 1'b0;
        case (op)
            OP_ROL, OP_ROR:          eff = int'(amt % WIDTH);
            OP_SHL, OP_SHR, OP_SHRA: eff = (amt > WIDTH) ? WIDTH : int'(amt);
            default: begin eff = 0; e.ill = 1'b1; end
        endcase
        e.res = a;
        for (int i = 0; i < WIDTH; i++) begin
            case (op)
                OP_SHL:  e.res[i] = (i >= eff) ? a[i-eff] : 1'b0;
                OP_SHR:  e.res[i] = (i + eff < WIDTH) ? a[i+eff] : 1'b0;
                OP_SHRA: e.res[i] = (i + eff < WIDTH) ? a[i+eff] : a[WIDTH-1];
                OP_ROL:  e.res[i] = a[(i - eff + WIDTH) % WIDTH];
                OP_ROR:  e.res[i] = a[(i + eff) % WIDTH];
                default: e.res[i] = a[i];
            endcase
        end
        if (eff > 0) begin
            case (op)
                OP_SHL, OP_ROL:          e.fc = a[WIDTH-eff];
                OP_SHR, OP_SHRA, OP_ROR: e.fc = a[eff-1];
                default:                 e.fc = 1'b0;
            endcase
        end
        e.lat = (eff + STEP - 1) / STEP;
        return e;
    endfunction

    // Present one request for one edge and record what it must produce
    task automatic issue(input logic [4:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] amt);
        bus.start   = 1'b1;
        bus.op_code = op;
        bus.a       = a;
        bus.amt     = amt;
        sb.push_back(model(op, a, amt));
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Count edges after the accept until done, bounded
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.op_code = 5'b00000; bus.a = '0; bus.amt = '0;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else passes++;
        checks++; if (bus.illegal !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", bus.illegal); else passes++;
        checks++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h expected 0", bus.result); else passes++;
        clr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rol;
        exp_t e; int lat;
        issue(OP_ROL, 32'h0000E7C4, 32'd5);
        checks++; if (bus.busy !== 1'b1) $display("FAIL rol_busy: got %b expected 1", bus.busy); else passes++;
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (bus.result !== 32'h001CF880 || e.res !== 32'h001CF880) $display("FAIL rol_result: got %h expected %h", bus.result, 32'h001CF880); else passes++;
        checks++; if (lat !== 2) $display("FAIL rol_latency: got %0d expected 2", lat); else passes++;
        checks++; if (bus.illegal !== 1'b0) $display("FAIL rol_illegal: got %b expected 0", bus.illegal); else passes++;
    endtask

    task automatic test_ror_wrap;
        exp_t e; int lat;
        issue(OP_ROR, 32'h00000001, 32'd33);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (bus.result !== 32'h80000000) $display("FAIL ror_result: got %h expected 80000000", bus.result); else passes++;
        checks++; if (lat !== e.lat) $display("FAIL ror_latency: got %0d expected %0d", lat, e.lat); else passes++;
`ifdef SHIFT_FLAGS_EN
        checks++; if (bus.flag_n !== 1'b1) $display("FAIL ror_flag_n: got %b expected 1", bus.flag_n); else passes++;
        checks++; if (bus.flag_c !== 1'b1) $display("FAIL ror_flag_c: got %b expected 1", bus.flag_c); else passes++;
        checks++; if (bus.flag_z !== 1'b0) $display("FAIL ror_flag_z: got %b expected 0", bus.flag_z); else passes++;
`endif
    endtask

    task automatic test_shra_clamp;
        exp_t e; int lat;
        issue(OP_SHRA, 32'h80000000, 32'd40);
        bus.op_code = OP_SHL; bus.a = 32'h1; bus.amt = 32'd1;
        repeat (3) begin
            bus.start = 1'b1;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        wait_done(lat);
        lat += 3;
        e = sb.pop_front();
        checks++; if (bus.result !== 32'hFFFFFFFF) $display("FAIL shra_result: got %h expected ffffffff", bus.result); else passes++;
        checks++; if (lat !== 8) $display("FAIL shra_latency: got %0d expected 8", lat); else passes++;
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL shra_no_queue: got done=%b busy=%b expected 0 0", bus.done, bus.busy); else passes++;
        checks++; if (bus.result !== e.res) $display("FAIL shra_hold: got %h expected %h", bus.result, e.res); else passes++;
    endtask

    task automatic test_zero_and_illegal;
        exp_t e; int lat;
        issue(OP_ROL, 32'h12345678, 32'd32);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (bus.result !== 32'h12345678) $display("FAIL rol0_result: got %h expected 12345678", bus.result); else passes++;
        checks++; if (lat !== 0) $display("FAIL rol0_latency: got %0d expected 0", lat); else passes++;
        issue(5'b00011, 32'hCAFEF00D, 32'd7);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (bus.result !== 32'hCAFEF00D) $display("FAIL ill_result: got %h expected cafef00d", bus.result); else passes++;
        checks++; if (bus.illegal !== e.ill || e.ill !== 1'b1) $display("FAIL ill_flag: got %b expected 1", bus.illegal); else passes++;
        checks++; if (lat !== 0) $display("FAIL ill_latency: got %0d expected 0", lat); else passes++;
        @(posedge clk); #1;
        checks++; if (bus.illegal !== 1'b0 || bus.done !== 1'b0) $display("FAIL ill_clear: got illegal=%b done=%b expected 0 0", bus.illegal, bus.done); else passes++;
    endtask

    task automatic test_reset_mid_run;
        exp_t e; int lat;
        issue(OP_SHL, 32'h0000000F, 32'd12);
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        void'(sb.pop_front());
        checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", bus.done); else passes++;
        checks++; if (bus.result !== 32'h0) $display("FAIL midrst_result: got %h expected 0", bus.result); else passes++;
        issue(OP_SHL, 32'h0000000F, 32'd12);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (bus.result !== 32'h0000F000) $display("FAIL midrst_after_result: got %h expected 0000f000", bus.result); else passes++;
        checks++; if (lat !== 3) $display("FAIL midrst_after_latency: got %0d expected 3", lat); else passes++;
    endtask

    task automatic test_back_to_back;
        exp_t e; int lat;
        issue(OP_SHR, 32'h000000F0, 32'd4);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (bus.result !== e.res) $display("FAIL b2b_first: got %h expected %h", bus.result, e.res); else passes++;
        issue(OP_SHL, 32'h00000001, 32'd4);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (bus.result !== 32'h00000010) $display("FAIL b2b_result: got %h expected 00000010", bus.result); else passes++;
        checks++; if (lat !== 1) $display("FAIL b2b_latency: got %0d expected 1", lat); else passes++;
    endtask

    task automatic test_random;
        exp_t e; int lat;
        logic [4:0] ops [6];
        ops[0] = OP_SHR; ops[1] = OP_SHRA; ops[2] = OP_SHL;
        ops[3] = OP_ROL; ops[4] = OP_ROR;  ops[5] = 5'b10001;
        for (int n = 0; n < 10; n++) begin
            issue(ops[$urandom_range(0, 5)], $urandom, 32'($urandom_range(0, 40)));
            wait_done(lat);
            e = sb.pop_front();
            checks++; if (bus.result !== e.res) $display("FAIL rand_result[%0d]: got %h expected %h", n, bus.result, e.res); else passes++;
            checks++; if (bus.illegal !== e.ill) $display("FAIL rand_illegal[%0d]: got %b expected %b", n, bus.illegal, e.ill); else passes++;
            checks++; if (lat !== e.lat) $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, e.lat); else passes++;
`ifdef SHIFT_FLAGS_EN
            checks++; if (bus.flag_c !== e.fc) $display("FAIL rand_flag_c[%0d]: got %b expected %b", n, bus.flag_c, e.fc); else passes++;
            checks++; if (bus.flag_z !== (e.res == '0)) $display("FAIL rand_flag_z[%0d]: got %b expected %b", n, bus.flag_z, (e.res == '0)); else passes++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_rol();
        test_ror_wrap();
        test_shra_clamp();
        test_zero_and_illegal();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/shift_rotate_unit.md
# shift_rotate_unit

Parametrised multi-cycle shift/rotate execution unit for the datapath ALU stage. It performs ROL, ROR, SHL, SHR and SHRA on a WIDTH-bit operand, moving up to STEP bit positions per clock. A start/busy/done handshake lets the control sequencer issue the operation in one step and collect the result into Z when done is high.

## Interface
- WIDTH, 32, operand/result width; must be a power of two, ≥ 8
- STEP, 4, maximum bit positions moved per clock; 1 ≤ STEP ≤ WIDTH
- clk  in  1  single clock; all state updates on its rising edge
- clr  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only while busy=0
- op_code  in  5  operation select (package constants)
- a  in  WIDTH  operand, latched on accept
- amt  in  WIDTH  shift/rotate amount, latched on accept
- result  out  WIDTH  shifted operand; valid while done=1, held until next accept
- busy  out  1  high in RUN
- done  out  1  high for exactly one cycle (DONE state)
- illegal  out  1  high with done when the accepted op_code is not a shift/rotate

## Operation
- States: IDLE, RUN, DONE. Accept = start & ~busy, in IDLE or DONE.
- Op codes: SHR 5'b00101, SHRA 5'b00110, SHL 5'b00111, ROL 5'b01000, ROR 5'b01001.
- Effective amount on accept: rotates use amt mod WIDTH (low log2(WIDTH) bits); shifts use min(amt, WIDTH); illegal op uses 0.
- On accept: load shift register with a, rem with the effective amount, latch op. If eff=0 → DONE, else → RUN.
- RUN, each edge: move by k = min(STEP, rem); rem -= k. SHL fills with 0 at bit 0. SHR fills with 0 at the MSB. SHRA fills with a[WIDTH-1]. ROL/ROR wrap bits around. When rem ≤ STEP → DONE.
- DONE, for one cycle: done=1 and illegal per the latched op. Then → IDLE unless a new accept occurs on that edge.
- start while busy=1 is ignored; it is not queued.
- Reset values (clr=0 at an edge, any state including mid-RUN): state IDLE, result 0, rem 0, busy 0, done 0, illegal 0, and flags 0 if present. A pending operation is discarded.

## Timing
- For an accept at edge k with n = ceil(eff/STEP), done is high in the cycle after edge k+n.
  - Example: eff=0 → done in the cycle right after the accept edge.
- busy is high from edge k+1 to edge k+n when n>0.
- result updates every RUN edge and is final and stable while done=1.
- Back-to-back: an accept during the DONE cycle starts a new operation. No idle cycle is required.

## Configuration
- SHIFT_FLAGS_EN defined: adds outputs flag_z, flag_n and flag_c, each 1 bit, registered and valid with done.
  - flag_z = result==0
  - flag_n = result[WIDTH-1]
  - flag_c = last bit shifted out, or last bit carried across the wrap for rotates; 0 when eff=0
- SHIFT_FLAGS_EN undefined: these ports and their registers do not exist. All other behaviour is identical.

## Structure
- The shared ALU package holds the op_code localparams (SHR, SHRA, SHL, ROL, ROR), the state enum typedef, and the ceil/clog2 helper.
- One sub-module, shift_step_mux: combinational single-step shifter (op, k, data in → data out, carry out). The top level owns the FSM, rem counter and registers.

## Test plan
- ROL, a=32'h0000E7C4, amt=5, STEP=4 → result 32'h001CF880, done 2 cycles after accept, illegal=0.
- ROR, a=32'h00000001, amt=33 → eff 1 → result 32'h80000000, done 1 cycle after accept; with flags: flag_n=1, flag_c=1.
- SHRA, a=32'h80000000, amt=40 → clamped to 32 → result 32'hFFFFFFFF after 8 RUN cycles; start pulses while busy are ignored.
- ROL, amt=32 → eff 0 → result=a, done in the cycle after accept. op_code=5'b00011 → result=a, illegal=1 with done.
- clr=0 at the 2nd RUN cycle of an SHL by 12 → next cycle busy=0, done=0, result=0. A new accept afterwards completes normally.
- Accept a second op (SHL 32'h1 by 4) during the DONE cycle of the first → done again 1 cycle later, result 32'h00000010.
